instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Front-end fetch stage that sits directly upstream of the instruction control decoder. Maintains the fetch PC and issues word reads to instruction memory over a valid/ready request channel. Collects in-order responses into a small prefetch FIFO and presents `{instr, instr_pc}` to decode with valid/ready. Handles control-flow redirects by flushing buffered words and discarding responses still in flight.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `FIFO_DEPTH`, 4, prefetch entries; also the cap on outstanding plus buffered words (power of two, ≥2)

- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `imem_req_valid`  out  1  request to instruction memory
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  word-aligned fetch address
- `imem_resp_valid`  in  1  response data valid; no backpressure
- `imem_resp_data`  in  32  fetched instruction word
- `redirect_valid`  in  1  branch/jump taken, restart fetch
- `redirect_pc`  in  32  new fetch target
- `instr_valid`  out  1  `instr`/`instr_pc` valid for decode
- `instr_ready`  in  1  decode consumes the word
- `instr`  out  32  instruction word to decoder
- `instr_pc`  out  32  address of `instr`

## Operation
- Registers: `fetch_pc`, `resp_pc`, `outstanding`, `drop_count`, FIFO. `outstanding` and `drop_count` are clog2(FIFO_DEPTH+1) bits wide.
- Credit rule: `imem_req_valid = !redirect_valid && (outstanding + count < FIFO_DEPTH)`. `imem_req_addr = fetch_pc`.
- Request fire (valid&ready): `fetch_pc += 4` (mod 2^32, wraps silently), `outstanding++`.
- Response (`imem_resp_valid`): `outstanding--`.
  - If `drop_count != 0`, discard the word and decrement `drop_count`.
  - Otherwise push `{imem_resp_data, resp_pc}` and `resp_pc += 4`.
  - The credit rule guarantees a push never overflows. Responses arrive in request order, never in the acceptance cycle.
- Pop: `instr_valid = (count != 0) && !redirect_valid`. Pop on `instr_valid && instr_ready`. FIFO head drives `instr`/`instr_pc`.
- Simultaneous push and pop: both take effect and count is unchanged. Pushing into an empty FIFO does not bypass to the output.
- Redirect (`redirect_valid`), which has priority over all other events:
  - FIFO flushed to count 0.
  - `fetch_pc` and `resp_pc` set to `{redirect_pc[31:2], 2'b00}`.
  - `drop_count <= outstanding - resp_fire`, so every in-flight response becomes a drop.
  - Any response in that cycle is discarded. No request and no pop occur that cycle.
- Back-to-back redirects: the second overwrites the target. `drop_count` is recomputed from the current `outstanding`.
- Reset: `fetch_pc = resp_pc = RESET_PC`, `outstanding = drop_count = 0`, FIFO empty. Instruction memory shares `reset`, so no stale responses follow a reset.
- Reset output values: `imem_req_valid = 0` while reset is asserted, `instr_valid = 0`, `imem_req_addr = RESET_PC`, `instr`/`instr_pc` = 0.

## Timing
- First request: `imem_req_valid = 1` in the first cycle after `reset` deasserts.
- Response to decode: a word pushed at edge N is visible as `instr_valid` in cycle N+1 (one-cycle latency).
- With a 1-cycle memory and decode always ready, steady-state throughput is one instruction per cycle.
- Request handshake:
  - `imem_req_addr` holds stable while `imem_req_valid && !imem_req_ready`.
  - `imem_req_valid` may drop without a fire only on `redirect_valid` or reset.
- Redirect to first new request: `imem_req_valid` asserts in the cycle after the redirect, with addr = new target.
- `instr_valid` and `imem_req_valid` depend combinationally on `redirect_valid`. All other outputs are registered.

## Structure
- Shared package `fetch_pkg`: `XLEN = 32`, `RESET_PC_DEFAULT`, instruction word width, and the packed struct `fetch_entry_t {instr, pc}`.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t` with a `flush` input plus `count`, `full` and `empty` outputs. Parameterised by depth.
- Credit, drop and PC logic live in `instruction_fetch_unit`.

## Test plan
- Streaming:
  - Stimulus: reset, 1-cycle memory, always ready.
  - Response: requests at 0x0, 0x4, 0x8…; `instr_pc` follows the same sequence one cycle behind the responses, one per cycle.
- Backpressure:
  - Stimulus: `instr_ready = 0`.
  - Response: exactly 4 requests fire (0x0–0xC), then `imem_req_valid` stays 0 with count = 4. Raising `instr_ready` drains 0x0 first and fetching resumes at 0x10.
- Redirect with 2 in flight:
  - Stimulus: 3-cycle memory, redirect to 0x100.
  - Response: both old responses are discarded. The next `instr_pc` is 0x100 with the correct data, and no pre-redirect word ever reaches decode.
- Misaligned redirect:
  - Stimulus: `redirect_pc = 0x103`.
  - Response: `imem_req_addr = 0x100` the next cycle.
- Memory stall:
  - Stimulus: `imem_req_ready = 0` for 5 cycles.
  - Response: addr held at the same value with valid high, and `fetch_pc` unchanged until the fire.
- Reset mid-stream:
  - Stimulus: assert `reset` with 3 words buffered and 1 outstanding.
  - Response: next cycle `instr_valid = 0`. After release the first request is at `RESET_PC`, with outstanding and drop counts at 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch front end.
//   XLEN             : address width
//   ILEN             : instruction word width
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fetch_entry_t    : prefetch buffer payload {instr, pc}
//   align_word()     : clears the byte offset of an address
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; drop the byte offset.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Synchronous prefetch FIFO of fetch_entry_t with a single-cycle flush.
// The head entry is presented directly from storage (no bypass of a push
// into an empty FIFO).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   flush           : empty the FIFO this cycle (wins over push/pop)
//   push, push_data : write one entry
//   pop             : retire the head entry
//   head            : current head entry
//   count           : number of stored entries
//   full, empty     : occupancy flags
// ----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage; cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
// Fetch stage: keeps the fetch PC, issues word reads to instruction memory
// under a credit limit, buffers in-order responses and hands {instr, pc} to
// decode. A redirect flushes the buffer and turns every in-flight response
// into a drop.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   imem_req_valid/ready/addr        : request channel to instruction memory
//   imem_resp_valid/data             : in-order responses, no backpressure
//   redirect_valid/pc                : restart fetch at a new target
//   instr_valid/ready, instr, instr_pc : instruction channel to decode
// ----------------------------------------------------------------------------
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_resp_valid,
    input  logic [ILEN-1:0]  imem_resp_data,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [ILEN-1:0]  instr,
    output logic [XLEN-1:0]  instr_pc
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_count;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            credit_ok;
    logic            req_fire;
    logic            resp_fire;
    logic            push;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // Outstanding plus buffered words may never exceed the buffer, so every
    // response that is not a drop always has a slot waiting for it.
    assign credit_ok = (SW'(outstanding) + SW'(count)) < SW'(FIFO_DEPTH);

    assign imem_req_valid = !reset && !redirect_valid && !full && credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_fire  = imem_resp_valid;
    assign push       = resp_fire && (drop_count == '0) && !redirect_valid;
    assign push_entry = {imem_resp_data, resp_pc};

    assign instr_valid = !reset && !redirect_valid && !empty;
    assign pop         = instr_valid && instr_ready;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    // PC, credit and drop bookkeeping; a redirect overrides every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_count  <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= align_word(redirect_pc);
            resp_pc     <= align_word(redirect_pc);
            outstanding <= outstanding - CW'(resp_fire);
            drop_count  <= outstanding - CW'(resp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (push) begin
                resp_pc <= resp_pc + XLEN'(4);
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_fire);
            if (resp_fire && (drop_count != '0)) begin
                drop_count <= drop_count - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed bench: a latency-programmable instruction memory, a transaction
// level reference model (expected fetch address, expected delivered PC,
// in-flight requests tagged with the redirect epoch they belong to) checked
// every cycle, plus hand-computed expectations for each scenario.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // ---------------- instruction memory ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];
    int    cyc = 0;
    int    lat = 1;

    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = memf(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    logic [31:0] m_fpc;      // next address the unit must request
    logic [31:0] m_dpc;      // next PC decode must receive
    int          m_out   = 0;
    int          m_buf   = 0;
    int          m_epoch = 0;
    int          m_fires = 0;
    int          eq[$];      // epoch of each in-flight request
    bit          chk_en  = 1'b0;

    initial begin
        logic  exp_rv;
        logic  exp_iv;
        int    resp_ep;
        mreq_t r;
        m_fpc = RST_PC;
        m_dpc = RST_PC;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_rv = !reset && !redirect_valid && (m_out + m_buf < DEPTH);
                exp_iv = !reset && !redirect_valid && (m_buf != 0);
                chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
                chk("req_addr", imem_req_addr, m_fpc);
                chk("instr_valid", 32'(instr_valid), 32'(exp_iv));
                if (instr_valid === 1'b1 && exp_iv) begin
                    chk("instr_pc", instr_pc, m_dpc);
                    chk("instr_data", instr, memf(m_dpc));
                end
            end
            // Advance the model across the coming clock edge.
            if (reset === 1'b1) begin
                m_fpc = RST_PC;
                m_dpc = RST_PC;
                m_out = 0;
                m_buf = 0;
                m_epoch++;
                mq.delete();
                eq.delete();
            end else begin
                resp_ep = -1;
                if (imem_resp_valid === 1'b1) begin
                    if (eq.size() > 0) resp_ep = eq.pop_front();
                    m_out--;
                end
                if (redirect_valid === 1'b1) begin
                    m_fpc = {redirect_pc[31:2], 2'b00};
                    m_dpc = {redirect_pc[31:2], 2'b00};
                    m_buf = 0;
                    m_epoch++;
                end else begin
                    if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
                        eq.push_back(m_epoch);
                        r.addr = m_fpc;
                        r.due  = cyc + lat;
                        mq.push_back(r);
                        m_fpc = m_fpc + 32'd4;
                        m_out++;
                        m_fires++;
                    end
                    if (resp_ep == m_epoch) m_buf++;
                    if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
                        m_buf--;
                        m_dpc = m_dpc + 32'd4;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset(input int l);
        tick();
        reset = 1'b1;
        lat   = l;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_instr(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            at_neg();
            if (instr_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: instr_valid never rose within 30 cycles", name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int f0;
        int got;
        bit ok;
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;

        // Reset values and streaming with a 1-cycle memory.
        tick();
        tick();
        at_neg();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        at_neg();
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0);
        chk("first_no_instr", 32'(instr_valid), 32'd0);
        at_neg();
        at_neg();
        chk("stream_v0", 32'(instr_valid), 32'd1);
        chk("stream_pc0", instr_pc, 32'h0);
        at_neg();
        chk("stream_pc1", instr_pc, 32'h4);
        chk("stream_d1", instr, 32'hDEAD_BEEB);
        got = 0;
        for (int i = 0; i < 10; i++) begin
            at_neg();
            if (instr_valid === 1'b1 && instr_ready === 1'b1) got++;
        end
        chk("stream_rate", 32'(got), 32'd10);

        // Backpressure: decode stalled, four words fill the buffer.
        instr_ready = 1'b0;
        apply_reset(1);
        f0 = m_fires;
        for (int i = 0; i < 10; i++) at_neg();
        chk("bp_fires", 32'(m_fires - f0), 32'd4);
        chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        instr_ready = 1'b1;
        at_neg();
        chk("bp_head_valid", 32'(instr_valid), 32'd1);
        chk("bp_head_pc", instr_pc, 32'h0);
        chk("bp_still_full", 32'(imem_req_valid), 32'd0);
        at_neg();
        chk("bp_resume_valid", 32'(imem_req_valid), 32'd1);
        chk("bp_resume_addr", imem_req_addr, 32'h10);

        // Redirect with two in flight on a 3-cycle memory, then a memory stall.
        apply_reset(3);
        tick();
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        f0 = m_fires;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("stall_valid", 32'(imem_req_valid), 32'd1);
            chk("stall_addr", imem_req_addr, 32'h100);
        end
        chk("stall_no_fire", 32'(m_fires - f0), 32'd0);
        tick();
        imem_req_ready = 1'b1;
        wait_instr("redir_wait", ok);
        if (ok) begin
            chk("redir_pc", instr_pc, 32'h100);
            chk("redir_data", instr, 32'hDEAD_BFEF);
        end

        // Misaligned redirect, then back-to-back redirects.
        apply_reset(1);
        for (int i = 0; i < 6; i++) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        tick();
        redirect_valid = 1'b0;
        at_neg();
        chk("misal_valid", 32'(imem_req_valid), 32'd1);
        chk("misal_addr", imem_req_addr, 32'h100);
        for (int i = 0; i < 6; i++) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        wait_instr("b2b_wait", ok);
        if (ok) begin
            chk("b2b_pc", instr_pc, 32'h300);
            chk("b2b_data", instr, 32'hDEAD_BDEF);
        end

        // Reset with three words buffered and one still outstanding.
        instr_ready = 1'b0;
        apply_reset(3);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            at_neg();
            if (m_buf == 3 && m_out == 1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL midrst_fill: 3 buffered / 1 outstanding never reached");
        end
        tick();
        reset = 1'b1;
        at_neg();
        chk("midrst_instr_valid", 32'(instr_valid), 32'd0);
        chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        tick();
        reset       = 1'b0;
        instr_ready = 1'b1;
        at_neg();
        chk("midrst_req_valid2", 32'(imem_req_valid), 32'd1);
        chk("midrst_req_addr", imem_req_addr, 32'h0);
        wait_instr("midrst_wait", ok);
        if (ok) begin
            chk("midrst_pc", instr_pc, 32'h0);
            chk("midrst_data", instr, 32'hDEAD_BEEF);
        end

        for (int i = 0; i < 4; i++) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
